// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store at a time over a valid/ready
// handshake and answers after LATENCY cycles. Handles byte/half/word accesses
// with sign/zero extension on loads and byte-lane merging on stores.
module dm_responder #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        accept, commit;

    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_sign;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] lat_pc;

    logic        cur_we;
    logic [1:0]  cur_size;
    logic        cur_sign;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] cur_pc;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [31:0]       word;
    logic              err;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       merged;
    logic [31:0]       load_data;

    // With LATENCY=1 the commit happens on the accepting edge itself, so the
    // commit datapath reads the live request in IDLE and the latched one after.
    always_comb begin
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_size  = req_size;
            cur_sign  = req_sign;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_pc    = req_pc;
        end else begin
            cur_we    = lat_we;
            cur_size  = lat_size;
            cur_sign  = lat_sign;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_pc    = lat_pc;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic, handshake outputs and accept/commit strobes
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nx = RESP;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                    commit   = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latch the request at the accepting edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_size  <= '0;
            lat_sign  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_pc    <= '0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_size  <= req_size;
            lat_sign  <= req_sign;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_pc    <= req_pc;
        end
    end

    // Latency counter: loaded on accept, counts down while waiting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          cnt <= '0;
        else if (accept)                     cnt <= 4'(CNT_INIT);
        else if (state == WAIT && cnt != '0) cnt <= cnt - 4'd1;
    end

    // Commit datapath: error check, lane extraction/extension, store merge
    always_comb begin
        idx  = cur_addr[ADDR_W+1:2];
        word = mem[idx];
        err  = (cur_size == 2'b11) |
               ((cur_size == 2'b01) & cur_addr[0]) |
               ((cur_size == 2'b10) & (cur_addr[1:0] != 2'b00));

        case (cur_addr[1:0])
            2'b00:   byte_sel = word[7:0];
            2'b01:   byte_sel = word[15:8];
            2'b10:   byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = cur_addr[1] ? word[31:16] : word[15:0];

        merged = word;
        case (cur_size)
            2'b00: begin
                case (cur_addr[1:0])
                    2'b00:   merged[7:0]   = cur_wdata[7:0];
                    2'b01:   merged[15:8]  = cur_wdata[7:0];
                    2'b10:   merged[23:16] = cur_wdata[7:0];
                    default: merged[31:24] = cur_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (cur_addr[1]) merged[31:16] = cur_wdata[15:0];
                else             merged[15:0]  = cur_wdata[15:0];
            end
            2'b10:   merged = cur_wdata;
            default: merged = word;
        endcase

        case (cur_size)
            2'b00:   load_data = cur_sign ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
            2'b01:   load_data = cur_sign ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
            2'b10:   load_data = word;
            default: load_data = '0;
        endcase
    end

    // Response registers: set on commit, held through RESP, cleared on handoff
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_err   <= err;
            resp_rdata <= (!cur_we && !err) ? load_data : '0;
        end else if (state == RESP && resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

    // Memory array: cleared on reset, written only by error-free store commits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit && cur_we && !err) begin
            mem[idx] <= merged;
        end
    end

`ifndef SYNTHESIS
    // Store log for simulation traces
    always_ff @(posedge clk) begin
        if (reset && commit && cur_we && !err)
            $display("@%h: *%h <= %h", cur_pc, {cur_addr[31:2], 2'b00}, merged);
    end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (ADDR_W=12, LATENCY=2).
module tb_dm_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    dm_responder #(.ADDR_W(12), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction. lat = edge count from accept to the edge where the
    // consumer first sees resp_valid; 0 when no response arrived in budget.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc, output logic [31:0] rdata,
                          output logic err, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
        req_addr = addr; req_wdata = wdata; req_pc = pc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        if (resp_valid === 1'b1) begin
            lat = n + 1;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
        end else begin
            lat = 0;
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic er; int lat;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", resp_err); end
        @(negedge clk); rst_n = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_load0: got %h want 00000000", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL reset_latency: got %0d want 2", lat); end
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL post_handoff: got valid=%b ready=%b want 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 32'h100, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL word_store_resp: got err=%b rdata=%h want 0 00000000", er, rd); end
        do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h104, rd, er, lat);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL word_load: got %h want 12345678", rd); end
    endtask

    task automatic test_subword;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 32'h108, rd, er, lat);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h10C, rd, er, lat);
        checks++; if (rd !== 32'h1234AB78) begin errors++; $display("FAIL byte_merge: got %h want 1234ab78", rd); end
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h110, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFAB) begin errors++; $display("FAIL byte_load_sext: got %h want ffffffab", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h114, rd, er, lat);
        checks++; if (rd !== 32'h000000AB) begin errors++; $display("FAIL byte_load_zext: got %h want 000000ab", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 32'h118, rd, er, lat);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11C, rd, er, lat);
        checks++; if (rd !== 32'h8001AB78) begin errors++; $display("FAIL half_merge: got %h want 8001ab78", rd); end
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h120, rd, er, lat);
        checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL half_load_sext: got %h want ffff8001", rd); end
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h124, rd, er, lat);
        checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL half_load_zext: got %h want 00008001", rd); end
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h128, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL byte3_load_sext: got %h want ffffff80", rd); end
        // byte store with junk in the upper wdata bits: only [7:0] lands
        do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hFFFFFF55, 32'h12C, rd, er, lat);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h130, rd, er, lat);
        checks++; if (rd !== 32'h8001AB55) begin errors++; $display("FAIL byte0_merge: got %h want 8001ab55", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000BEEF, 32'h134, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL half_misaligned: got err=%b rdata=%h want 1 00000000", er, rd); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h138, rd, er, lat);
        checks++; if (rd !== 32'h8001AB55 || er !== 1'b0) begin errors++; $display("FAIL err_no_write: got err=%b rdata=%h want 0 8001ab55", er, rd); end
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h13C, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL size11: got err=%b rdata=%h want 1 00000000", er, rd); end
        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h140, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL word_misaligned: got err=%b rdata=%h want 1 00000000", er, rd); end
        do_req(1'b1, 2'b10, 1'b0, 32'h11, 32'hFFFFFFFF, 32'h144, rd, er, lat);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h148, rd, er, lat);
        checks++; if (rd !== 32'h8001AB55) begin errors++; $display("FAIL word_misaligned_nowrite: got %h want 8001ab55", rd); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic er; int lat; int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        // requester keeps valid up and scribbles a store while not ready
        req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hFFFFFFFF;
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_timeout: got %b want 1", resp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h8001AB55 || req_ready !== 1'b0 || resp_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b rdata=%h ready=%b err=%b want 1 8001ab55 0 0", i, resp_valid, resp_rdata, req_ready, resp_err);
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b rdata=%h ready=%b want 0 00000000 1", resp_valid, resp_rdata, req_ready); end
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h14C, rd, er, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bp_ignored_store: got %h want 00000000", rd); end
    endtask

    task automatic test_wrap;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 2'b10, 1'b0, 32'h4010, 32'h0, 32'h150, rd, er, lat);
        checks++; if (rd !== 32'h8001AB55) begin errors++; $display("FAIL wrap_load: got %h want 8001ab55", rd); end
        do_req(1'b1, 2'b10, 1'b0, 32'hFFFFC020, 32'hCAFEF00D, 32'h154, rd, er, lat);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h158, rd, er, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_store: got %h want cafef00d", rd); end
    endtask

    task automatic test_reset_midop;
        logic [31:0] rd; logic er; int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_sign = 1'b0;
        req_addr = 32'h24; req_wdata = 32'hDEADBEEF; req_pc = 32'h15C;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL midop_wait: got valid=%b ready=%b want 0 0", resp_valid, req_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL midop_async: got ready=%b valid=%b want 1 0", req_ready, resp_valid); end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h160, rd, er, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midop_target: got %h want 00000000", rd); end
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h164, rd, er, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midop_cleared: got %h want 00000000", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL midop_latency: got %0d want 2", lat); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_sign = 1'b0; req_addr = '0; req_wdata = '0; req_pc = '0;
        resp_ready = 1'b0;
        test_reset;
        test_word;
        test_subword;
        test_half;
        test_errors;
        test_backpressure;
        test_wrap;
        test_reset_midop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
